// File: rtl/vga_pkg.sv
// Shared types and constants for the frame-buffer access scheduler.
package vga_pkg;

    localparam int H_DISPLAY = 800;
    localparam int V_DISPLAY = 600;
    localparam int COLOR_W   = 24;
    localparam int ADDR_W    = 19;

    typedef logic [COLOR_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0]  fb_addr_t;

    // Address is resolved before the push, so the FIFO only carries RAM-ready data.
    typedef struct packed {
        fb_addr_t addr;
        pixel_t   data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // y*800 + x without a multiplier: 800 = 512 + 256 + 32.
    function automatic fb_addr_t pix_addr(input logic [10:0] x, input logic [9:0] y);
        fb_addr_t w_y;
        w_y = fb_addr_t'(y);
        return (w_y << 9) + (w_y << 8) + (w_y << 5) + fb_addr_t'(x);
    endfunction

endpackage

// File: rtl/fb_access_scheduler_fifo.sv
// Write-request FIFO: small register-file FIFO with flush, full/empty and level.
module fb_write_fifo
    import vga_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  wr_entry_t       i_push_data,
    input  logic            i_pop,
    input  logic            i_flush,
    output wr_entry_t       o_head,
    output logic            o_full,
    output logic            o_empty,
    output logic [PTR_W:0]  o_level
);

    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    wr_entry_t      r_mem [DEPTH];
    logic           w_push;
    logic           w_pop;

    // Flush overrides both push and pop for the cycle.
    assign w_push  = i_push & ~o_full  & ~i_flush;
    assign w_pop   = i_pop  & ~o_empty & ~i_flush;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Pointer update: flush empties the FIFO, otherwise independent push/pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/fb_access_scheduler.sv
// Single-port frame-buffer arbiter: scan-out fetches own active video,
// buffered writer requests drain during blanking.
module fb_access_scheduler
    import vga_pkg::*;
#(
    parameter  int FIFO_DEPTH   = 16,
    parameter  int READ_LATENCY = 1,
    localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_blank_n,
    input  logic [10:0]        i_next_x,
    input  logic [9:0]         i_next_y,
    input  logic               i_wr_valid,
    output logic               o_wr_ready,
    input  logic [10:0]        i_wr_x,
    input  logic [9:0]         i_wr_y,
    input  logic [COLOR_W-1:0] i_wr_data,
    input  logic               i_flush,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic               o_mem_we,
    output logic [COLOR_W-1:0] o_mem_wdata,
    input  logic [COLOR_W-1:0] i_mem_rdata,
    output logic [COLOR_W-1:0] o_pixel_data,
    output logic               o_pixel_valid,
    output logic [LVL_W-1:0]   o_fifo_level,
    output logic               o_wr_dropped
);

    sched_state_t         r_state;
    sched_state_t         w_state_next;
    fb_addr_t             r_mem_addr;
    fb_addr_t             w_mem_addr_next;
    pixel_t               r_mem_wdata;
    pixel_t               w_mem_wdata_next;
    wr_entry_t            w_head;
    wr_entry_t            w_push_entry;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_in_range;
    logic                 w_push;
    logic                 w_pop;
    logic                 r_ready_en;
    logic                 r_dropped;
    logic [READ_LATENCY:0] r_blank_pipe;
    pixel_t               r_pixel_data;
    logic                 r_pixel_valid;

    // Ready is held low until the first edge after reset release.
    assign o_wr_ready   = r_ready_en & ~w_full;
    assign w_accept     = i_wr_valid & o_wr_ready;
    assign w_in_range   = (i_wr_x < 11'(H_DISPLAY)) && (i_wr_y < 10'(V_DISPLAY));
    assign w_push       = w_accept & w_in_range;
    assign w_push_entry = '{addr: pix_addr(i_wr_x, i_wr_y), data: i_wr_data};
    assign w_pop        = (w_state_next == DRAIN);

    fb_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (i_flush),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (o_fifo_level)
    );

    // Owner selection: active video always fetches; writes only in blanking.
    always_comb begin
        w_state_next     = IDLE;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        if (i_blank_n) begin
            w_state_next    = FETCH;
            w_mem_addr_next = pix_addr(i_next_x, i_next_y);
        end else if (!w_empty && !i_flush) begin
            w_state_next     = DRAIN;
            w_mem_addr_next  = w_head.addr;
            w_mem_wdata_next = w_head.data;
        end
    end

    // Registered RAM port; reset drops any in-flight write immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_we    = (r_state == DRAIN);
    assign o_mem_wdata = r_mem_wdata;

    // Writer-side status: ready enable and sticky drop flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready_en <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_accept && !w_in_range) r_dropped <= 1'b1;
        end
    end

    // blank_n tracks the address register and RAM read stages.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blank_pipe <= '0;
        end else begin
            r_blank_pipe[0] <= i_blank_n;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                r_blank_pipe[i] <= r_blank_pipe[i-1];
            end
        end
    end

    // Output pixel register, forced to black outside active video.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pixel_data  <= '0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_pixel_valid <= r_blank_pipe[READ_LATENCY];
            r_pixel_data  <= r_blank_pipe[READ_LATENCY] ? i_mem_rdata : '0;
        end
    end

    assign o_pixel_data  = r_pixel_data;
    assign o_pixel_valid = r_pixel_valid;
    assign o_wr_dropped  = r_dropped;

endmodule

// File: tb/tb_fb_access_scheduler.sv
// Bench for fb_access_scheduler: behavioural RAM, queue-based scheduler model,
// per-cycle compare and directed literal checks.
module tb_fb_access_scheduler;

    logic        clk;
    logic        rst_n;
    logic        blank_n;
    logic [10:0] nx;
    logic [9:0]  ny;
    logic        wv;
    logic [10:0] wx;
    logic [9:0]  wy;
    logic [23:0] wd;
    logic        flush;
    logic        o_wr_ready;
    logic [18:0] o_mem_addr;
    logic        o_mem_we;
    logic [23:0] o_mem_wdata;
    logic [23:0] mem_rdata;
    logic [23:0] o_pixel_data;
    logic        o_pixel_valid;
    logic [4:0]  o_fifo_level;
    logic        o_wr_dropped;

    int n_checks = 0;
    int n_errors = 0;

    fb_access_scheduler dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_blank_n     (blank_n),
        .i_next_x      (nx),
        .i_next_y      (ny),
        .i_wr_valid    (wv),
        .o_wr_ready    (o_wr_ready),
        .i_wr_x        (wx),
        .i_wr_y        (wy),
        .i_wr_data     (wd),
        .i_flush       (flush),
        .o_mem_addr    (o_mem_addr),
        .o_mem_we      (o_mem_we),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .o_pixel_data  (o_pixel_data),
        .o_pixel_valid (o_pixel_valid),
        .o_fifo_level  (o_fifo_level),
        .o_wr_dropped  (o_wr_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Initial RAM content: a simple address hash so every read is distinguishable.
    function automatic logic [23:0] base_val(input int a);
        int v;
        v = a * 40503 + 32'h5A5A5A;
        return v[23:0];
    endfunction

    // Behavioural single-port RAM, one-cycle registered read.
    logic [23:0] ram [0:524287];
    initial begin
        for (int i = 0; i < 524288; i++) ram[i] = base_val(i);
    end
    always @(posedge clk) begin
        mem_rdata <= ram[o_mem_addr];
        if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- scheduler model ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [23:0] d;
    } ent_t;

    ent_t        m_q[$];
    logic [23:0] m_img [int];
    bit          m_rdy_en;
    int          m_addr;
    bit          m_we;
    logic [23:0] m_wdata;
    bit          m_dropped;
    bit          m_pv [3];
    logic [23:0] m_pd [3];

    function automatic logic [23:0] img_rd(input int a);
        if (m_img.exists(a)) return m_img[a];
        return base_val(a);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit   acc;
        bit   inr;
        ent_t e;
        if (!rst_n) begin
            m_q.delete();
            m_rdy_en  = 0;
            m_addr    = 0;
            m_we      = 0;
            m_wdata   = '0;
            m_dropped = 0;
            for (int i = 0; i < 3; i++) begin
                m_pv[i] = 0;
                m_pd[i] = '0;
            end
        end else begin
            acc = wv && m_rdy_en && (m_q.size() < 16);
            inr = (int'(wx) < 800) && (int'(wy) < 600);
            // a write issued last cycle lands in the RAM at this edge
            if (m_we) m_img[m_addr] = m_wdata;
            if (acc && !inr) m_dropped = 1;
            m_pv[2] = m_pv[1];
            m_pd[2] = m_pd[1];
            m_pv[1] = m_pv[0];
            m_pd[1] = m_pd[0];
            m_pv[0] = blank_n;
            m_pd[0] = blank_n ? img_rd(int'(ny) * 800 + int'(nx)) : 24'h0;
            m_we = 0;
            if (blank_n) begin
                m_addr = int'(ny) * 800 + int'(nx);
            end else if (!flush && m_q.size() > 0) begin
                e       = m_q.pop_front();
                m_addr  = e.a;
                m_wdata = e.d;
                m_we    = 1;
            end
            if (flush) m_q.delete();
            else if (acc && inr) m_q.push_back('{a: int'(wy) * 800 + int'(wx), d: wd});
            m_rdy_en = 1;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("level", 32'(o_fifo_level), m_q.size());
            chk("wr_ready", 32'(o_wr_ready), 32'(m_rdy_en && (m_q.size() < 16)));
            chk("mem_we", 32'(o_mem_we), 32'(m_we));
            chk("mem_addr", 32'(o_mem_addr), m_addr);
            if (m_we) chk("mem_wdata", 32'(o_mem_wdata), 32'(m_wdata));
            chk("pixel_valid", 32'(o_pixel_valid), 32'(m_pv[2]));
            chk("pixel_data", 32'(o_pixel_data), 32'(m_pd[2]));
            chk("wr_dropped", 32'(o_wr_dropped), 32'(m_dropped));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (blank_n) nx = (nx == 11'd799) ? 11'd0 : nx + 11'd1;
        end
    endtask

    int          nwe;
    logic [18:0] cap_addr [4];
    logic [23:0] cap_data0;

    initial begin
        rst_n = 1'b1; blank_n = 1'b0; nx = '0; ny = '0;
        wv = 1'b0; wx = '0; wy = '0; wd = '0; flush = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_wr_ready", 32'(o_wr_ready), 0);
        chk("rst_mem_we", 32'(o_mem_we), 0);
        chk("rst_level", 32'(o_fifo_level), 0);
        chk("rst_pixel_valid", 32'(o_pixel_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rel_wr_ready_low", 32'(o_wr_ready), 0);
        step(1);
        chk("rel_wr_ready_high", 32'(o_wr_ready), 1);

        // scan-out latency: (5,2) -> address 1605
        blank_n = 1'b1; nx = 11'd5; ny = 10'd2;
        step(1);
        chk("t1_mem_addr", 32'(o_mem_addr), 1605);
        blank_n = 1'b0;
        step(2);
        chk("t1_pixel_valid", 32'(o_pixel_valid), 1);
        chk("t1_pixel_data", 32'(o_pixel_data), 32'(base_val(1605)));

        // four writes during active video, drained in blanking in order
        blank_n = 1'b1; nx = '0; ny = '0;
        for (int i = 0; i < 4; i++) begin
            wv = 1'b1; wx = 11'(10 + i); wy = '0; wd = 24'hAAAA01 + 24'(i);
            step(1);
        end
        wv = 1'b0; blank_n = 1'b0; nwe = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (o_mem_we) begin
                if (nwe < 4) cap_addr[nwe] = o_mem_addr;
                if (nwe == 0) cap_data0 = o_mem_wdata;
                nwe++;
            end
        end
        chk("t2_we_count", nwe, 4);
        chk("t2_addr0", 32'(cap_addr[0]), 10);
        chk("t2_addr3", 32'(cap_addr[3]), 13);
        chk("t2_data0", 32'(cap_data0), 32'h00AAAA01);
        chk("t2_level", 32'(o_fifo_level), 0);
        blank_n = 1'b1; nx = 11'd11; ny = '0;
        step(1);
        blank_n = 1'b0;
        step(2);
        chk("t2_readback", 32'(o_pixel_data), 32'h00AAAA02);

        // fill to 16 during active video, 17th held off
        blank_n = 1'b1; nx = '0; ny = 10'd9;
        for (int i = 0; i < 16; i++) begin
            wv = 1'b1; wx = 11'(i); wy = 10'd1; wd = 24'h100000 + 24'(i);
            step(1);
        end
        chk("t3_level_full", 32'(o_fifo_level), 16);
        chk("t3_ready_full", 32'(o_wr_ready), 0);
        wx = 11'd100; wd = 24'h1000FF;
        step(2);
        chk("t3_held_off", 32'(o_fifo_level), 16);
        blank_n = 1'b0;
        step(1);
        chk("t3_first_pop_level", 32'(o_fifo_level), 15);
        chk("t3_ready_again", 32'(o_wr_ready), 1);
        step(1);
        chk("t3_push_pop_level", 32'(o_fifo_level), 15);
        wv = 1'b0;
        step(20);
        chk("t3_drained", 32'(o_fifo_level), 0);

        // out-of-range writes are dropped, boundary (799,599) is kept
        chk("t4_dropped_clear", 32'(o_wr_dropped), 0);
        wv = 1'b1; wx = 11'd800; wy = 10'd0; wd = 24'h0BAD01;
        step(1);
        chk("t4_x_level", 32'(o_fifo_level), 0);
        chk("t4_x_dropped", 32'(o_wr_dropped), 1);
        wx = 11'd0; wy = 10'd600;
        step(1);
        chk("t4_y_level", 32'(o_fifo_level), 0);
        wx = 11'd799; wy = 10'd599; wd = 24'hC0FFEE;
        step(1);
        chk("t4_corner_level", 32'(o_fifo_level), 1);
        wv = 1'b0;
        step(1);
        chk("t4_corner_we", 32'(o_mem_we), 1);
        chk("t4_corner_addr", 32'(o_mem_addr), 479999);
        step(3);
        chk("t4_dropped_sticky", 32'(o_wr_dropped), 1);

        // blanking ends with 3 entries pending
        blank_n = 1'b1; nx = '0; ny = 10'd8;
        for (int i = 0; i < 5; i++) begin
            wv = 1'b1; wx = 11'(200 + i); wy = 10'd3; wd = 24'h300000 + 24'(i);
            step(1);
        end
        wv = 1'b0; blank_n = 1'b0;
        step(2);
        chk("t5_level_pending", 32'(o_fifo_level), 3);
        blank_n = 1'b1; nx = 11'd50; ny = 10'd7;
        step(1);
        chk("t5_fetch_we", 32'(o_mem_we), 0);
        chk("t5_fetch_addr", 32'(o_mem_addr), 5650);
        step(3);
        chk("t5_level_hold", 32'(o_fifo_level), 3);
        blank_n = 1'b0;
        step(5);
        chk("t5_level_done", 32'(o_fifo_level), 0);

        // flush with a concurrent write at level 5
        blank_n = 1'b1; nx = '0; ny = 10'd9;
        for (int i = 0; i < 5; i++) begin
            wv = 1'b1; wx = 11'(300 + i); wy = 10'd4; wd = 24'h400000 + 24'(i);
            step(1);
        end
        chk("t6_level5", 32'(o_fifo_level), 5);
        wx = 11'd400; flush = 1'b1; blank_n = 1'b0;
        step(1);
        chk("t6_flush_level", 32'(o_fifo_level), 0);
        chk("t6_flush_we", 32'(o_mem_we), 0);
        flush = 1'b0; wv = 1'b0; nwe = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (o_mem_we) nwe++;
        end
        chk("t6_no_writes", nwe, 0);
        blank_n = 1'b1; nx = 11'd300; ny = 10'd4;
        step(1);
        blank_n = 1'b0;
        step(2);
        chk("t6_unwritten", 32'(o_pixel_data), 32'(base_val(3500)));

        // reset in the middle of a drain
        blank_n = 1'b1; nx = '0; ny = 10'd9;
        for (int i = 0; i < 3; i++) begin
            wv = 1'b1; wx = 11'(500 + i); wy = 10'd5; wd = 24'h500000 + 24'(i);
            step(1);
        end
        wv = 1'b0; blank_n = 1'b0;
        step(1);
        chk("t7_drain_we", 32'(o_mem_we), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_we", 32'(o_mem_we), 0);
        chk("t7_rst_level", 32'(o_fifo_level), 0);
        chk("t7_rst_ready", 32'(o_wr_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1);
        chk("t7_ready_back", 32'(o_wr_ready), 1);
        blank_n = 1'b1; nx = 11'd500; ny = 10'd5;
        step(1);
        blank_n = 1'b0;
        step(2);
        chk("t7_abandoned", 32'(o_pixel_data), 32'(base_val(4500)));

        step(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
